// File: rtl/meter_seg_scan_if.sv
// Display-stage bus for meter_seg_scan: value/point/enable in, busy and
// multiplexed seven-segment drive out.
interface meter_seg_scan_if;
    logic [19:0] data_in;
    logic [5:0]  point;
    logic        seg_en;
    logic        conv_busy;
    logic [5:0]  sel;
    logic [7:0]  seg;

    modport master (output data_in, point, seg_en, input conv_busy, sel, seg);
    modport slave  (input data_in, point, seg_en, output conv_busy, sel, seg);
endinterface

// File: rtl/meter_seg_scan.sv
// Binary-to-BCD double-dabble converter feeding a six-digit common-anode scan.
// Define SEG_LZ_BLANK_EN to blank leading zeros not covered by a decimal point.
module meter_seg_scan #(
    parameter logic [15:0] CNT_SCAN = 16'd49_999
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    meter_seg_scan_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    conv_state_t state;
    logic [19:0] src_q;
    logic [19:0] bin_q;
    logic [23:0] bcd_work;
    logic [23:0] bcd_adj;
    logic [23:0] bcd_q;
    logic [4:0]  bit_cnt;
    logic [19:0] bin_load;

    logic [15:0] scan_cnt;
    logic [2:0]  dig_idx;
    logic [3:0]  nib;
    logic        dp_bit;
    logic        blank_bit;
    logic [5:0]  blank;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'h40;
            4'd1:    font = 7'h79;
            4'd2:    font = 7'h24;
            4'd3:    font = 7'h30;
            4'd4:    font = 7'h19;
            4'd5:    font = 7'h12;
            4'd6:    font = 7'h02;
            4'd7:    font = 7'h78;
            4'd8:    font = 7'h00;
            4'd9:    font = 7'h10;
            default: font = 7'h7F;
        endcase
    endfunction

    assign bin_load = (bus.data_in > 20'd999_999) ? 20'd999_999 : bus.data_in;

    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < 6; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    // src_q holds the raw input so an out-of-range value does not retrigger
    // conversion every time it is compared against the saturated result.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            src_q         <= '0;
            bin_q         <= '0;
            bcd_work      <= '0;
            bcd_q         <= '0;
            bit_cnt       <= '0;
            bus.conv_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_in != src_q) begin
                        src_q         <= bus.data_in;
                        bin_q         <= bin_load;
                        bcd_work      <= '0;
                        bit_cnt       <= '0;
                        bus.conv_busy <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_work, bin_q} <= {bcd_adj, bin_q} << 1;
                    bit_cnt           <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd19)
                        state <= DONE;
                end
                DONE: begin
                    bcd_q         <= bcd_work;
                    bus.conv_busy <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic lz_run;
    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            lz_run   = lz_run & (bcd_q[4*i +: 4] == 4'd0) & ~bus.point[i];
            blank[i] = lz_run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        nib       = bcd_q[3:0];
        dp_bit    = bus.point[0];
        blank_bit = blank[0];
        case (dig_idx)
            3'd1: begin nib = bcd_q[7:4];   dp_bit = bus.point[1]; blank_bit = blank[1]; end
            3'd2: begin nib = bcd_q[11:8];  dp_bit = bus.point[2]; blank_bit = blank[2]; end
            3'd3: begin nib = bcd_q[15:12]; dp_bit = bus.point[3]; blank_bit = blank[3]; end
            3'd4: begin nib = bcd_q[19:16]; dp_bit = bus.point[4]; blank_bit = blank[4]; end
            3'd5: begin nib = bcd_q[23:20]; dp_bit = bus.point[5]; blank_bit = blank[5]; end
            default: ;
        endcase
    end

    // The segment register follows bcd_q every cycle, so a fresh conversion
    // shows up mid-dwell instead of at the next digit boundary.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !bus.seg_en) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            bus.sel  <= 6'h3F;
            bus.seg  <= 8'hFF;
        end else begin
            if (scan_cnt == CNT_SCAN) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            bus.sel <= ~(6'b1 << dig_idx);
            bus.seg <= {~dp_bit, blank_bit ? 7'h7F : font(nib)};
        end
    end

endmodule

// File: tb/tb_meter_seg_scan.sv
// Scoreboard bench for meter_seg_scan: conversions are queued at issue time
// and checked by a monitor when conv_busy falls; scan frames are checked live.
module tb_meter_seg_scan;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meter_seg_scan_if bus ();

    meter_seg_scan #(.CNT_SCAN(16'd3)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [23:0] expQ[$];
    int   lastSrc = 0;
    logic prevBusy = 1'b0;
    logic [6:0] fontTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int satVal(input int v);
        return (v > 999999) ? 999999 : v;
    endfunction

    function automatic logic [23:0] toBcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = satVal(v);
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] expSeg(input int v, input logic [5:0] p, input int i);
        int x, pw, d;
        logic blankIt;
        logic [5:0] hiPoint;
        x  = satVal(v);
        pw = 1;
        for (int k = 0; k < i; k++) pw = pw * 10;
        d = (x / pw) % 10;
        hiPoint = p >> i;
        blankIt = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        if (i > 0 && (x / pw) == 0 && hiPoint == 6'd0) blankIt = 1'b1;
`endif
        if (hiPoint == 6'h3F) blankIt = blankIt;
        return {~p[i], blankIt ? 7'h7F : fontTab[d]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int value);
        @(posedge clk);
        #1;
        bus.data_in = 20'(value);
        if (value != lastSrc) expQ.push_back(toBcd(value));
        lastSrc = value;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((expQ.size() != 0 || bus.conv_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout waiting for conversion", name);
        end
    endtask

    task automatic waitBusy(input logic level, input string name);
        int n;
        n = 0;
        while (bus.conv_busy !== level && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout waiting for busy=%0b", name, level);
        end
    endtask

    task automatic checkFrame(input int v, input logic [5:0] p);
        logic [5:0] prevSel;
        logic found;
        found = 1'b0;
        @(negedge clk);
        prevSel = bus.sel;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (bus.sel == 6'h3E && prevSel != 6'h3E) found = 1'b1;
            else prevSel = bus.sel;
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_align no digit-0 start seen");
        end else begin
            for (int k = 0; k < 24; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput("frame_sel", {26'd0, bus.sel}, {26'd0, ~(6'b1 << (k / 4))});
                checkOutput("frame_seg", {24'd0, bus.seg}, {24'd0, expSeg(v, p, k / 4)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (prevBusy && !bus.conv_busy && !rst) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL conv_unexpected got=%0h exp=none", dut.bcd_q);
            end else begin
                checkOutput("conv_result", {8'd0, dut.bcd_q}, {8'd0, expQ.pop_front()});
            end
        end
        prevBusy = bus.conv_busy;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int v;
        rst         = 1'b1;
        bus.data_in = '0;
        bus.point   = '0;
        bus.seg_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_sel",  {26'd0, bus.sel}, 32'h3F);
        checkOutput("rst_seg",  {24'd0, bus.seg}, 32'hFF);
        checkOutput("rst_busy", {31'd0, bus.conv_busy}, 32'd0);
        checkOutput("rst_bcd",  {8'd0, dut.bcd_q}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(0);
        repeat (4) @(negedge clk);
        checkOutput("zero_no_conv", {31'd0, bus.conv_busy}, 32'd0);

        applyStimulus(12345);
        waitBusy(1'b1, "busy_rise");
        cnt = 0;
        while (bus.conv_busy && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("busy_len", cnt, 32'd21);
        waitDone("conv_12345");

        applyStimulus(987654);
        waitDone("conv_987654");
        checkFrame(987654, 6'b0);

        applyStimulus(20'hFFFFF);
        waitDone("conv_sat");
        checkFrame(20'hFFFFF, 6'b0);

        applyStimulus(100);
        waitBusy(1'b1, "chg_rise");
        repeat (4) @(posedge clk);
        applyStimulus(250);
        @(negedge clk);
        waitBusy(1'b0, "chg_fall");
        cnt = 0;
        while (!bus.conv_busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("chg_gap", cnt, 32'd1);
        waitDone("conv_250");

        bus.point = 6'b000010;
        applyStimulus(85);
        waitDone("conv_85");
        checkFrame(85, 6'b000010);

        for (int r = 0; r < 8; r++) begin
            v = int'($urandom_range(0, 20'hFFFFF));
            if (r % 3 == 0) v = v % 1000;
            if (v == lastSrc) v = v ^ 1;
            bus.point = 6'($urandom);
            applyStimulus(v);
            waitDone("conv_rand");
            checkFrame(v, bus.point);
        end

        @(posedge clk);
        #1 bus.seg_en = 1'b0;
        applyStimulus(4321);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            checkOutput("dis_sel", {26'd0, bus.sel}, 32'h3F);
            checkOutput("dis_seg", {24'd0, bus.seg}, 32'hFF);
        end
        waitDone("conv_disabled");
        @(posedge clk);
        #1 bus.seg_en = 1'b1;
        checkFrame(4321, bus.point);

        applyStimulus(55555);
        waitBusy(1'b1, "rst_mid_rise");
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstmid_busy", {31'd0, bus.conv_busy}, 32'd0);
        checkOutput("rstmid_bcd",  {8'd0, dut.bcd_q}, 32'd0);
        checkOutput("rstmid_sel",  {26'd0, bus.sel}, 32'h3F);
        @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
        expQ.push_back(toBcd(55555));
        lastSrc = 55555;
        waitDone("conv_after_rst");
        checkFrame(55555, bus.point);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/meter_seg_scan.md
# meter_seg_scan

Downstream display stage of the taxi meter. Takes the 20-bit binary value the metering logic produces (fare or distance count) and converts it to six BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed, common-anode six-digit seven-segment display. Conversion and scanning run independently, so the displayed value only changes once a complete conversion has finished.

## Interface
- `CNT_SCAN`, default 16'd49_999: dwell per digit minus one, in `sys_clk` cycles (1 ms at 50 MHz).
- `sys_clk`, input, 1: system clock, 50 MHz.
- `sys_rst`, input, 1: synchronous, active-high reset, sampled on the `sys_clk` rising edge.
- `data_in`, input, 20: binary value to display, unsigned.
- `point`, input, 6: decimal-point mask; bit i lights the dp of digit i.
- `seg_en`, input, 1: display enable; 0 blanks every digit.
- `conv_busy`, output, 1: high while a conversion is in progress.
- `sel`, output, 6: digit select, active-low; bit 0 is the units (rightmost) digit.
- `seg`, output, 8: segments, active-low; `seg[6:0]` = g,f,e,d,c,b,a and `seg[7]` = dp.

## Operation
- **Source latch:** `src_q` is a 20-bit latched copy of the value being shown.
- **Conversion FSM:** states IDLE, SHIFT, DONE.
  - IDLE: when `data_in != src_q`, latch `data_in` into `src_q` and clear the 24-bit BCD working register. Load the shift register with `data_in`, or with 20'd999_999 if `data_in` > 999_999 (saturate). Go to SHIFT and set `conv_busy` = 1.
  - SHIFT: 20 iterations, one per cycle. In each iteration, add 3 to every BCD nibble that is ≥ 5, then shift {bcd, bin} left by 1. A 5-bit counter counts 0..19; after iteration 19 go to DONE.
  - DONE: copy the working BCD into the 24-bit display register `bcd_q`, clear `conv_busy`, return to IDLE.
  - `data_in` changes while the FSM is in SHIFT or DONE are ignored until IDLE. The IDLE compare then catches the new value, so the newest stable value is always converted eventually.
- **Scan:**
  - `scan_cnt` counts 0..`CNT_SCAN`. When it wraps, `dig_idx` advances 0→1→…→5→0.
  - `sel` = ~(6'b1 << `dig_idx`).
  - `seg[6:0]` is the font for nibble `bcd_q[4*dig_idx +: 4]`.
  - `seg[7]` = ~`point[dig_idx]`.
- **Font** (active-low, g..a): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Any nibble > 9 shows blank, 7'h7F.
- **seg_en = 0:** `sel` = 6'h3F and `seg` = 8'hFF. `scan_cnt` and `dig_idx` are held at 0. Conversion keeps running.
- **Outputs:** `sel` and `seg` are registered.

## Timing
- **Reset values:** `sel` = 6'h3F, `seg` = 8'hFF, `conv_busy` = 0, `bcd_q` = 0, `src_q` = 0, `scan_cnt` = 0, `dig_idx` = 0, FSM in IDLE.
- **Reset mid-conversion:** the conversion is aborted and everything returns to the reset values above. After reset is released, a nonzero `data_in` starts a new conversion.
- **Conversion latency:** a change sampled in IDLE at cycle N raises `conv_busy` at N+1. The SHIFT iterations occupy N+1..N+20, DONE is at N+21, and `bcd_q` is valid (with `conv_busy` low) at N+22.
- **Scan timing:** the digit dwell is `CNT_SCAN`+1 cycles. A full frame is 6×(`CNT_SCAN`+1) cycles.
- **Output latency:** `sel`/`seg` lag `dig_idx`/`bcd_q` by one registered cycle.
- **Display update:** a `bcd_q` update mid-dwell takes effect on the next cycle, without waiting for the digit boundary.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking is enabled.
  - Digit i (i > 0) shows 7'h7F on `seg[6:0]` when every nibble at positions ≥ i is zero and `point` has no bit set at positions ≥ i.
  - Digit 0 is never blanked.
  - `sel` timing is unchanged.
- `SEG_LZ_BLANK_EN` undefined: all six digits always show their font, including leading zeros.

## Test plan
- **Reset/basic conversion:** `sys_rst` = 1 for 2 cycles, then `data_in` = 20'd0, then `data_in` = 20'd12345 → `conv_busy` is high for exactly 21 cycles, then `bcd_q` = 24'h012345.
- **Scan sequence:** with `CNT_SCAN` = 3, `seg_en` = 1, `data_in` = 20'd987654 → `sel` steps 3E, 3D, 3B, 37, 2F, 1F with a 4-cycle dwell each; `seg[6:0]` = 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10 respectively.
- **Saturation:** `data_in` = 20'hFFFFF → `bcd_q` = 24'h999999.
- **Change during conversion:** change `data_in` 100→250 at the 5th SHIFT cycle → the first conversion finishes with 000100; a second conversion starts one cycle after DONE and ends with 000250.
- **Blanking and dp:** `data_in` = 20'd85, `point` = 6'b000010.
  - With `SEG_LZ_BLANK_EN`: digits 5..2 show 7'h7F; digit 1 shows 7'h00 with `seg[7]` = 0; digit 0 shows 7'h12.
  - Without `SEG_LZ_BLANK_EN`: digits 5..2 show 7'h40.
- **Enable and reset:** `seg_en` = 0 → `sel` = 6'h3F and `seg` = 8'hFF while a conversion still completes. Assert `sys_rst` mid-SHIFT → `conv_busy` = 0 and `bcd_q` = 0 on the next cycle.
